// File: rtl/md_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : md_unit_pkg
// Brief    : Opcode encodings, FSM state type and op-class helpers for md_unit.
// Revision : 1.0 - initial release
// ============================================================================
package md_unit_pkg;

    localparam int MD_OP_W = 3;

    localparam logic [MD_OP_W-1:0] MD_NOP   = 3'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd4;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd5;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    function automatic logic is_mul(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : md_unit_if
// Brief    : Issue/result bundle between the execute-stage controller and md_unit.
// Revision : 1.0 - initial release
// ============================================================================
interface md_unit_if #(
    parameter int WIDTH = 32
);
    logic                              start;
    logic [md_unit_pkg::MD_OP_W-1:0]   md_op;
    logic [WIDTH-1:0]                  A;
    logic [WIDTH-1:0]                  B;
    logic                              cancel;
    logic                              busy;
    logic [WIDTH-1:0]                  hi;
    logic [WIDTH-1:0]                  lo;

    modport master (
        output start, md_op, A, B, cancel,
        input  busy, hi, lo
    );

    modport slave (
        input  start, md_op, A, B, cancel,
        output busy, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/md_arith.sv
`default_nettype none
// ============================================================================
// Module   : md_arith
// Brief    : Combinational multiply/divide datapath producing {hi,lo} and div0.
// Revision : 1.0 - initial release
// ============================================================================
module md_arith
    import md_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic [MD_OP_W-1:0]   op,
    input  wire logic [WIDTH-1:0]     a,
    input  wire logic [WIDTH-1:0]     b,
    output logic      [2*WIDTH-1:0]   result,
    output logic                      div0
);
    localparam logic [WIDTH-1:0] c_min = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic                       w_div0;
    logic                       w_min_neg1;
    logic signed [2*WIDTH-1:0]  w_sa_ext;
    logic signed [2*WIDTH-1:0]  w_sb_ext;
    logic        [2*WIDTH-1:0]  w_ua_ext;
    logic        [2*WIDTH-1:0]  w_ub_ext;
    logic signed [WIDTH-1:0]    w_sa;
    logic signed [WIDTH-1:0]    w_sdiv;
    logic signed [WIDTH-1:0]    w_squo;
    logic signed [WIDTH-1:0]    w_srem;
    logic        [WIDTH-1:0]    w_udiv;

    assign w_div0     = (b == '0);
    assign w_min_neg1 = (a == c_min) && (b == '1);

    assign w_sa_ext = {{WIDTH{a[WIDTH-1]}}, a};
    assign w_sb_ext = {{WIDTH{b[WIDTH-1]}}, b};
    assign w_ua_ext = {{WIDTH{1'b0}}, a};
    assign w_ub_ext = {{WIDTH{1'b0}}, b};

    // Divisor is forced to 1 on div-by-zero so the divider never sees zero;
    // the result is discarded later via div0.
    assign w_sa   = a;
    assign w_sdiv = w_div0 ? c_one : b;
    assign w_udiv = w_div0 ? c_one : b;
    assign w_squo = w_sa / w_sdiv;
    assign w_srem = w_sa % w_sdiv;

    always_comb begin
        result = '0;
        div0   = 1'b0;
        case (op)
            MD_MULT:  result = w_sa_ext * w_sb_ext;
            MD_MULTU: result = w_ua_ext * w_ub_ext;
            MD_DIV: begin
                div0 = w_div0;
                if (w_min_neg1) begin
                    result = {{WIDTH{1'b0}}, c_min};
                end else begin
                    result = {w_srem, w_squo};
                end
            end
            MD_DIVU: begin
                div0   = w_div0;
                result = {a % w_udiv, a / w_udiv};
            end
            default: result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module   : md_unit
// Brief    : Multi-cycle MULT/DIV unit with HI/LO, busy handshake, cancel, MTHI/MTLO.
// Revision : 1.0 - initial release
// ============================================================================
module md_unit
    import md_unit_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  wire logic   clk,
    input  wire logic   reset,
    md_unit_if.slave    bus
);
    localparam logic [CNT_W-1:0] c_mult_cnt = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] c_div_cnt  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    md_state_t            r_state;
    logic                 r_busy;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_pend_hi;
    logic [WIDTH-1:0]     r_pend_lo;
    logic                 r_pend_div0;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic [2*WIDTH-1:0]   w_result;
    logic                 w_div0;
    logic                 w_issue;

    md_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .op     (bus.md_op),
        .a      (bus.A),
        .b      (bus.B),
        .result (w_result),
        .div0   (w_div0)
    );

    // cancel in IDLE suppresses any same-edge issue
    assign w_issue = bus.start && !bus.cancel;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
            r_pend_hi   <= '0;
            r_pend_lo   <= '0;
            r_pend_div0 <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        if (is_mul(bus.md_op) || is_div(bus.md_op)) begin
                            {r_pend_hi, r_pend_lo} <= w_result;
                            r_pend_div0            <= w_div0;
                            r_cnt                  <= is_mul(bus.md_op) ? c_mult_cnt : c_div_cnt;
                            r_state                <= ST_RUN;
                            r_busy                 <= 1'b1;
                        end else if (bus.md_op == MD_MTHI) begin
                            r_hi <= bus.A;
                        end else if (bus.md_op == MD_MTLO) begin
                            r_lo <= bus.A;
                        end
                    end
                end
                ST_RUN: begin
                    // start is deliberately ignored here; cancel beats completion
                    if (bus.cancel || (r_cnt == c_cnt_one)) begin
                        if (!bus.cancel && !r_pend_div0) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_cnt       <= '0;
                        r_pend_hi   <= '0;
                        r_pend_lo   <= '0;
                        r_pend_div0 <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multiply/divide unit with HI/LO registers, in the style of the MIPS MULT/DIV family.
- Next-generation companion to the CPU datapath: width and operation latencies are generic, and it adds a busy handshake, a cancel input and MTHI/MTLO writes.
- Sits beside the ALU in the execute stage. The controller stalls issue while `busy` or `start` is high.

Parameters:
- WIDTH, 32: operand and HI/LO width in bits.
- MULT_CYCLES, 5: busy cycles for MULT/MULTU; minimum 1.
- DIV_CYCLES, 10: busy cycles for DIV/DIVU; minimum 1.
- CNT_W, 4: counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  issue strobe for `md_op`.
- md_op  input  3  NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; 7 is reserved and treated as NOP.
- A  input  WIDTH  operand rs (dividend/multiplicand; write data for MTHI/MTLO).
- B  input  WIDTH  operand rt (divisor/multiplier).
- cancel  input  1  aborts an in-flight MULT/DIV (exception flush).
- busy  output  1  operation in flight; registered.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset==0 at a rising edge):
  - hi=0, lo=0, busy=0, counter=0, pending result cleared.
  - Overrides every other input, including in mid-operation.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter counts down.
- IDLE, start=1, op MULT/MULTU/DIV/DIVU:
  - Compute the 2*WIDTH result from A and B as sampled on this edge and latch it into pending registers.
  - Load counter with MULT_CYCLES or DIV_CYCLES and enter RUN.
  - busy goes high in the next cycle.
- RUN:
  - Counter decrements each cycle.
  - On the edge where the counter goes 1 to 0, hi/lo take the pending values and the unit returns to IDLE.
  - busy is high for exactly N cycles, and the new hi/lo are visible in the first cycle busy is low.
- MTHI/MTLO with start=1 in IDLE:
  - hi (or lo) <= A on that edge; latency 1; busy stays 0.
- NOP or reserved op with start=1: no effect.
- start=1 while busy=1: ignored (controller contract violation). State and pending result are unchanged.
- cancel=1 in RUN:
  - Return to IDLE on that edge; busy=0 next cycle.
  - hi/lo keep their pre-operation values; pending result discarded.
- cancel=1 in IDLE:
  - Suppresses a same-edge start (nothing issues).
  - Otherwise no effect.
- cancel on the completing edge (counter==1): cancel wins and hi/lo are not updated.
- MULT: signed WIDTH×WIDTH product; hi=upper WIDTH bits, lo=lower WIDTH bits.
- MULTU: same as MULT, unsigned.
- DIV (signed):
  - lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - MIN / -1: lo=MIN, hi=0.
- DIVU: unsigned quotient in lo, remainder in hi.
- Divide by zero (DIV or DIVU): the operation runs its full latency with busy asserted, then hi/lo are left unchanged.
- hi/lo are only ever modified by reset, a completing MULT/DIV, or MTHI/MTLO.

Decomposition:
- Shared package: md_op encodings (MD_NOP..MD_MTLO) and the MD_OP_W=3 constant, as macros alongside the existing opcode macros in the shared macro file.
- One natural sub-module: md_arith, purely combinational. Inputs are op, A and B; outputs are the 2*WIDTH result and a div0 flag.
- md_unit holds the FSM, counter, pending registers and HI/LO.

Test Plan:
- Reset with reset=0 for 2 cycles:
  - hi=0, lo=0, busy=0.
  - A MULT issued in the same cycle as reset is discarded.
- MULT A=0xFFFFFFFE (-2), B=3:
  - busy=1 for exactly 5 cycles.
  - Next cycle hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- Unsigned forms:
  - MULTU A=0xFFFFFFFF, B=2 gives hi=1, lo=0xFFFFFFFE.
  - DIVU A=7, B=2: busy=1 for exactly 10 cycles, then lo=3, hi=1.
- Signed division:
  - DIV A=-7, B=2 gives lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV A=0x80000000, B=0xFFFFFFFF gives lo=0x80000000, hi=0.
  - DIV A=5, B=0 holds busy 10 cycles, then hi/lo unchanged.
- MTHI/MTLO and ignored start:
  - MTHI A=0x12345678 gives hi=0x12345678 the next cycle, busy stays 0.
  - start=1 with MTLO during a running MULT is ignored; the MULT result is committed normally.
- cancel:
  - cancel asserted in the 3rd busy cycle of a MULT gives busy=0 next cycle and hi/lo keep prior values.
  - cancel on the final busy cycle also blocks the update.
  - A new DIV issued immediately after completes normally.
